lfsr_scrambler_param: RTL and testbench
=======================================

LFSR_SCRAMBLER_PARAM -- requirements
Module: lfsr_scrambler_param

Interface
REQ-001 Parameter DATA_W, default 8: data beat width in bits, >= 1.
REQ-002 Parameter LFSR_W, default 8: LFSR state width in bits, >= 2.
REQ-003 Parameter TAPS, default 8'hA0: LFSR_W-bit feedback tap mask; bit k set means state[k] feeds the XOR.
REQ-004 Parameter SEED, default 8'hFF: LFSR_W-bit state value loaded at reset; must be non-zero.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 mode  input  1  0 = additive (frame-synchronous), 1 = multiplicative (self-synchronous).
REQ-008 descramble  input  1  multiplicative mode only: 0 = scramble, 1 = descramble; ignored when mode=0.
REQ-009 seed_load  input  1  load seed_val into the LFSR state.
REQ-010 seed_val  input  LFSR_W  seed value for seed_load.
REQ-011 in_valid  input  1  in_data is valid.
REQ-012 in_ready  output  1  block can accept a beat.
REQ-013 in_data  input  DATA_W  input beat.
REQ-014 out_valid  output  1  out_data is valid.
REQ-015 out_ready  input  1  downstream accepts out_data.
REQ-016 out_data  output  DATA_W  scrambled or descrambled beat.
REQ-017 beat_cnt  output  16  count of accepted input beats; wraps 0xFFFF -> 0x0000.

Function
REQ-018 A beat SHALL be accepted when in_valid && in_ready; it SHALL be transferred out when out_valid && out_ready.
REQ-019 in_ready SHALL equal (!out_valid || out_ready) && !seed_load.
REQ-020 An accepted beat SHALL appear on out_data with out_valid=1 on the next cycle (latency 1), giving full throughput of one beat per cycle with no bubbles.
REQ-021 out_data and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-022 out_valid SHALL clear after a transfer in any cycle where no new beat is accepted.
REQ-023 Each beat SHALL be processed as DATA_W serial bit-steps within one cycle, MSB of in_data first; the LFSR advances only on accepted beats.
REQ-024 Each bit-step SHALL compute fb = XOR-reduce(state & TAPS) and set out_bit = in_bit ^ fb.
REQ-025 In a bit-step, state SHALL become {state[LFSR_W-2:0], s}, where s is:
- fb when mode=0;
- out_bit when mode=1 and descramble=0;
- in_bit when mode=1 and descramble=1.
REQ-026 out_data bit (DATA_W-1-i) SHALL be the out_bit of bit-step i.
REQ-027 seed_load=1 SHALL set state to seed_val on the next edge.
REQ-028 If seed_val is all-zero, seed_load SHALL load SEED instead, so that lock-up is avoided.
REQ-029 seed_load SHALL NOT alter out_data, out_valid or beat_cnt; a pending output still transfers normally during seed_load.
REQ-030 A change of mode or descramble SHALL take effect on the next accepted beat; state SHALL NOT be altered by the change.
REQ-031 beat_cnt SHALL increment by 1 per accepted beat, modulo 2^16.

Reset
REQ-032 While rst=1 at a rising edge, the next-cycle values SHALL be:
- state = SEED;
- out_valid = 0, out_data = 0;
- beat_cnt = 0;
- in_ready = 1 on the first cycle after rst deasserts.
REQ-033 rst SHALL take priority over seed_load and over beat acceptance; a beat presented during reset SHALL be dropped.
REQ-034 Reset asserted mid-stream with out_valid=1 SHALL discard the pending beat.

Verification
REQ-035 Default parameters, mode=0, out_ready=1, after reset: in_data 0x00, 0x00 -> out_data 0x03, 0x0F; beat_cnt=2.
REQ-036 Round trip, multiplicative mode: 256 random beats are scrambled by one instance and descrambled by a second instance with the same SEED -> output equals input bit-exact. A second run starts the descrambler with a different seed -> all beats after the first ceil(LFSR_W/DATA_W)+1 match (self-synchronisation).
REQ-037 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1.
- Required: out_data stable, in_ready=0, beat_cnt frozen.
- On release: no beat is lost or duplicated, and the sequence matches the reference model.
REQ-038 seed_load with seed_val=0x00 in the same cycle as in_valid=1:
- the beat is not accepted;
- state becomes 0xFF;
- the next beat 0x00 -> 0x03.
REQ-039 Assert rst with out_valid=1 mid-stream: next cycle out_valid=0, beat_cnt=0, and the next beat 0x00 -> 0x03.
REQ-040 beat_cnt wrap: accept 65537 beats -> beat_cnt=1.

Source files
------------

// File: rtl/lfsr_scrambler_param.sv
// Parameterised LFSR scrambler/descrambler with a one-beat valid/ready output register.
// Supports additive (frame-synchronous) and multiplicative (self-synchronous) modes.
module lfsr_scrambler_param #(
    parameter int                DATA_W = 8,
    parameter int                LFSR_W = 8,
    parameter logic [LFSR_W-1:0] TAPS   = 8'hA0,
    parameter logic [LFSR_W-1:0] SEED   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              descramble,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_val,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       beat_cnt
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] next_state;
    logic [DATA_W-1:0] scr_data;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic [15:0]       beat_cnt_q;
    logic              accept;

    logic [LFSR_W-1:0] lfsr;
    logic              in_bit;
    logic              fb;
    logic              out_bit;
    logic              shift_in;

    assign in_ready = (!out_valid_q || out_ready) && !seed_load;
    assign accept   = in_valid && in_ready;

    // Unrolled bit-serial processing: DATA_W LFSR steps per beat, MSB first.
    // NOTE: blocking assignments here are intentional -- each loop iteration must
    // see the state produced by the previous one within the same evaluation.
    always_comb begin
        lfsr     = state_q;
        scr_data = '0;
        in_bit   = 1'b0;
        fb       = 1'b0;
        out_bit  = 1'b0;
        shift_in = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            in_bit  = in_data[DATA_W-1-i];
            fb      = ^(lfsr & TAPS);
            out_bit = in_bit ^ fb;
            if (!mode)
                shift_in = fb;
            else if (descramble)
                shift_in = in_bit;
            else
                shift_in = out_bit;
            scr_data[DATA_W-1-i] = out_bit;
            lfsr = {lfsr[LFSR_W-2:0], shift_in};
        end
        next_state = lfsr;
    end

    // An all-zero state would lock the additive LFSR, so a zero seed falls back to SEED.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEED;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            beat_cnt_q  <= '0;
        end else begin
            if (seed_load)
                state_q <= (seed_val == '0) ? SEED : seed_val;
            else if (accept)
                state_q <= next_state;

            if (accept) begin
                out_data_q  <= scr_data;
                out_valid_q <= 1'b1;
                beat_cnt_q  <= beat_cnt_q + 16'd1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_lfsr_scrambler_param.sv
// Directed bench for lfsr_scrambler_param: reset, known vectors, backpressure,
// seed loading, mode switching, mid-stream reset, counter wrap and round trips.
module tb_lfsr_scrambler_param;

    logic        clk = 1'b0;
    logic        rst, mode, descramble, seed_load, in_valid, out_ready;
    logic [7:0]  seed_val, in_data;
    logic        in_ready, out_valid;
    logic [7:0]  out_data;
    logic [15:0] beat_cnt;

    logic        rx_rst, rx_seed_load, rx_in_valid;
    logic [7:0]  rx_seed_val, rx_in_data;
    logic        rx_in_ready, rx_out_valid;
    logic [7:0]  rx_out_data;
    logic [15:0] rx_beat_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] orig [256];
    logic [7:0] scr  [256];
    logic [7:0] mst, exp_d;

    always #5 clk = ~clk;

    lfsr_scrambler_param u_dut (
        .clk(clk), .rst(rst), .mode(mode), .descramble(descramble),
        .seed_load(seed_load), .seed_val(seed_val),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .beat_cnt(beat_cnt)
    );

    lfsr_scrambler_param u_rx (
        .clk(clk), .rst(rx_rst), .mode(1'b1), .descramble(1'b1),
        .seed_load(rx_seed_load), .seed_val(rx_seed_val),
        .in_valid(rx_in_valid), .in_ready(rx_in_ready), .in_data(rx_in_data),
        .out_valid(rx_out_valid), .out_ready(1'b1), .out_data(rx_out_data),
        .beat_cnt(rx_beat_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reference for the default configuration (taps at bits 7 and 5).
    function automatic void model(input logic [7:0] st_in, input logic [7:0] d,
                                  input logic m, input logic dsc,
                                  output logic [7:0] st_out, output logic [7:0] q);
        logic [7:0] st;
        logic b, f, o;
        st = st_in;
        q  = 8'h00;
        for (int k = 7; k >= 0; k--) begin
            b    = d[k];
            f    = st[7] ^ st[5];
            o    = b ^ f;
            q[k] = o;
            st   = {st[6:0], (m ? (dsc ? b : o) : f)};
        end
        st_out = st;
    endfunction

    initial begin
        rst = 1'b1; mode = 1'b0; descramble = 1'b0; seed_load = 1'b0; seed_val = 8'h00;
        in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        rx_rst = 1'b1; rx_seed_load = 1'b0; rx_seed_val = 8'h00; rx_in_valid = 1'b0; rx_in_data = 8'h00;

        // Reset with a beat presented: beat dropped, clean state afterwards
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0; rx_rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data",  32'(out_data),  32'h00);
        check("rst_beat_cnt",  32'(beat_cnt),  32'h0);
        check("rst_in_ready",  32'(in_ready),  32'h1);

        // Known additive vectors, back to back
        in_valid = 1'b1; in_data = 8'h00;
        tick();
        check("add_v0_valid", 32'(out_valid), 32'h1);
        check("add_v0_data",  32'(out_data),  32'h03);
        tick();
        in_valid = 1'b0;
        check("add_v1_data",  32'(out_data),  32'h0F);
        check("add_cnt2",     32'(beat_cnt),  32'h2);
        tick();
        check("add_valid_clr", 32'(out_valid), 32'h0);

        // Backpressure: five stalled cycles with in_valid held high
        do_reset();
        mst = 8'hFF;
        in_valid = 1'b1; in_data = 8'h3C;
        tick();
        model(mst, 8'h3C, 1'b0, 1'b0, mst, exp_d);
        check("bp_first", 32'(out_data), 32'(exp_d));
        out_ready = 1'b0; in_data = 8'h55;
        #1;
        check("bp_in_ready_comb", 32'(in_ready), 32'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_data",  32'(out_data),  32'(exp_d));
            check("bp_hold_valid", 32'(out_valid), 32'h1);
            check("bp_in_ready",   32'(in_ready),  32'h0);
            check("bp_cnt_frozen", 32'(beat_cnt),  32'h1);
        end
        out_ready = 1'b1;
        tick();
        model(mst, 8'h55, 1'b0, 1'b0, mst, exp_d);
        check("bp_release", 32'(out_data), 32'(exp_d));
        in_data = 8'hAA;
        tick();
        in_valid = 1'b0;
        model(mst, 8'hAA, 1'b0, 1'b0, mst, exp_d);
        check("bp_next", 32'(out_data), 32'(exp_d));
        check("bp_cnt",  32'(beat_cnt), 32'h3);
        tick();

        // seed_load with zero seed collides with a valid beat
        do_reset();
        in_valid = 1'b1; in_data = 8'h12;
        tick();
        seed_load = 1'b1; seed_val = 8'h00; in_data = 8'h77;
        #1;
        check("sl_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("sl_no_accept_valid", 32'(out_valid), 32'h0);
        check("sl_no_accept_cnt",   32'(beat_cnt),  32'h1);
        seed_load = 1'b0; in_data = 8'h00;
        tick();
        check("sl_zero_seed", 32'(out_data), 32'h03);
        // Non-zero seed while an output is stalled: output untouched
        in_valid = 1'b0; out_ready = 1'b0; seed_load = 1'b1; seed_val = 8'hC0;
        tick();
        check("sl_hold_valid", 32'(out_valid), 32'h1);
        check("sl_hold_data",  32'(out_data),  32'h03);
        check("sl_hold_cnt",   32'(beat_cnt),  32'h2);
        seed_load = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h00;
        tick();
        in_valid = 1'b0;
        check("sl_c0_seed", 32'(out_data), 32'hC3);
        tick();

        // Mode switching keeps state: descramble of zeros empties the register
        do_reset();
        mode = 1'b1; descramble = 1'b1; in_valid = 1'b1; in_data = 8'h00;
        tick();
        check("mode_desc", 32'(out_data), 32'h03);
        mode = 1'b0; descramble = 1'b0; in_data = 8'h5A;
        tick();
        check("mode_add_zero_state", 32'(out_data), 32'h5A);
        mode = 1'b1; in_data = 8'hFF;
        tick();
        in_valid = 1'b0; mode = 1'b0;
        check("mode_mult_scr", 32'(out_data), 32'hFC);
        tick();

        // Reset mid-stream with a stalled output
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h00;
        tick();
        check("mr_pending", 32'(out_valid), 32'h1);
        rst = 1'b1; in_data = 8'h99;
        tick();
        rst = 1'b0;
        check("mr_valid", 32'(out_valid), 32'h0);
        check("mr_cnt",   32'(beat_cnt),  32'h0);
        check("mr_data",  32'(out_data),  32'h00);
        out_ready = 1'b1; in_data = 8'h00;
        tick();
        in_valid = 1'b0;
        check("mr_next", 32'(out_data), 32'h03);
        check("mr_cnt1", 32'(beat_cnt), 32'h1);

        // beat_cnt wrap
        do_reset();
        in_valid = 1'b1; in_data = 8'h00;
        repeat (65535) tick();
        check("cnt_ffff", 32'(beat_cnt), 32'hFFFF);
        repeat (2) tick();
        in_valid = 1'b0;
        check("cnt_wrap", 32'(beat_cnt), 32'h1);

        // Multiplicative round trip: scramble on u_dut, descramble on u_rx
        do_reset();
        mode = 1'b1; descramble = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            orig[i] = 8'($urandom_range(255));
            in_data = orig[i];
            tick();
            scr[i] = out_data;
        end
        in_valid = 1'b0;
        rx_rst = 1'b1; tick(); rx_rst = 1'b0;
        rx_in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            rx_in_data = scr[i];
            tick();
            check("rt_same_seed", 32'(rx_out_data), 32'(orig[i]));
        end
        rx_in_valid = 1'b0;
        // Mismatched descrambler seed: self-synchronises after two beats
        rx_rst = 1'b1; tick(); rx_rst = 1'b0;
        rx_seed_load = 1'b1; rx_seed_val = 8'h5A; tick(); rx_seed_load = 1'b0;
        rx_in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            rx_in_data = scr[i];
            tick();
            if (i >= 2)
                check("rt_self_sync", 32'(rx_out_data), 32'(orig[i]));
        end
        rx_in_valid = 1'b0;
        mode = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
